// File: rtl/stream_I_pkg.sv
// Shared types and defaults for the stream_I receiver blocks.
package stream_I_pkg;

    localparam int WORD_W    = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_decrypt_stream_i_fifo.sv
// Keystream word FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate occupancy register.
module ks_fifo_stream_I
    import stream_I_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      push,
    input  logic [WORD_W-1:0]         din,
    input  logic                      pop,
    output logic [WORD_W-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_LVL);
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/stream_decrypt_stream_i.sv
// Pairs buffered keystream words with incoming ciphertext and delivers the XOR
// as plaintext; flags keystream overflow as a loss of synchronisation.
//
// state | meaning
// IDLE  | waiting for start; no keystream accepted, ct_ready low
// RUN   | keystream buffered, ciphertext decrypted one word per cycle
// ERR   | keystream overflowed; only a held plaintext word may drain
module stream_decrypt_stream_i
    import stream_I_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                ks_valid,
    input  logic [WORD_W-1:0]   ks_in,
    input  logic                ct_valid,
    input  logic [WORD_W-1:0]   ct_data,
    output logic                ct_ready,
    output logic                pt_valid,
    output logic [WORD_W-1:0]   pt_data,
    input  logic                pt_ready,
    output logic                err,
    output logic [CNT_W-1:0]    pt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic [WORD_W-1:0] fifo_dout;
    logic              ct_fire;
    logic              pt_fire;
    logic              overflow;

    ks_fifo_stream_I #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .push  (fifo_push),
        .din   (ks_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (state_q == RUN && overflow) begin
            state_d = ERR;
        end
    end

    // A start cycle accepts nothing, so no ciphertext word is lost to the clear.
    always_comb begin
        ct_ready  = 1'b0;
        fifo_push = 1'b0;
        overflow  = 1'b0;
        if (state_q == RUN && !start) begin
            ct_ready  = !fifo_empty && (!pt_valid || pt_ready);
            fifo_push = ks_valid && ((fifo_count != FULL_LVL) || (ct_valid && ct_ready));
            overflow  = ks_valid && fifo_full && !(ct_valid && ct_ready);
        end
    end

    assign ct_fire  = ct_valid && ct_ready;
    assign pt_fire  = pt_valid && pt_ready;
    assign fifo_pop = ct_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            pt_valid <= 1'b0;
            pt_data  <= '0;
            pt_count <= '0;
            err      <= 1'b0;
        end else if (start) begin
            pt_valid <= 1'b0;
            pt_count <= '0;
            err      <= 1'b0;
        end else begin
            if (ct_fire) begin
                pt_valid <= 1'b1;
                pt_data  <= ct_data ^ fifo_dout;
            end else if (pt_fire) begin
                pt_valid <= 1'b0;
            end
            if (pt_fire)  pt_count <= pt_count + CNT_W'(1);
            if (overflow) err      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_decrypt_stream_i.sv
// Directed bench for the keystream decrypt stage; counter width is narrowed
// so the wrap boundary is reached in a few cycles.
module tb_stream_decrypt_stream_i;

    localparam int TB_CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ks_valid = 1'b0;
    logic [31:0] ks_in = '0;
    logic        ct_valid = 1'b0;
    logic [31:0] ct_data = '0;
    logic        ct_ready;
    logic        pt_valid;
    logic [31:0] pt_data;
    logic        pt_ready = 1'b0;
    logic        err;
    logic [TB_CNT_W-1:0] pt_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_decrypt_stream_i #(.DEPTH(4), .CNT_W(TB_CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ks_valid (ks_valid),
        .ks_in    (ks_in),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready),
        .err      (err),
        .pt_count (pt_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ksw(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {b, 8'hC3, ~b, 8'h5A};
    endfunction

    function automatic logic [31:0] ctw(input int n);
        return 32'(n) * 32'h9E37_79B9;
    endfunction

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ct_ready", 32'(ct_ready), 0);
        chk("rst_pt_valid", 32'(pt_valid), 0);
        chk("rst_pt_data", pt_data, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pt_count", 32'(pt_count), 0);

        // IDLE ignores traffic
        ks_valid = 1'b1; ks_in = 32'hFFFF_0000; ct_valid = 1'b1;
        #1 chk("idle_ct_ready", 32'(ct_ready), 0);
        tick();
        ks_valid = 1'b0; ct_valid = 1'b0;

        // basic two-word decryption
        start = 1'b1;
        tick();
        start = 1'b0;
        ks_valid = 1'b1; ks_in = 32'hA5A5_A5A5;
        tick();
        ks_in = 32'h0F0F_0F0F;
        tick();
        ks_valid = 1'b0;
        pt_ready = 1'b1; ct_valid = 1'b1; ct_data = 32'hFFFF_FFFF;
        #1 chk("t1_ct_ready0", 32'(ct_ready), 1);
        tick();
        chk("t1_pt0", pt_data, 32'h5A5A_5A5A);
        chk("t1_pv0", 32'(pt_valid), 1);
        ct_data = 32'h1234_5678;
        #1 chk("t1_ct_ready1", 32'(ct_ready), 1);
        tick();
        chk("t1_pt1", pt_data, 32'h1D3B_5977);
        chk("t1_pv1", 32'(pt_valid), 1);
        ct_valid = 1'b0;
        #1 chk("t1_empty_ready", 32'(ct_ready), 0);
        tick();
        chk("t1_pv_clr", 32'(pt_valid), 0);
        chk("t1_count", 32'(pt_count), 2);

        // empty FIFO stalls ciphertext; no same-cycle bypass
        ct_valid = 1'b1; ct_data = 32'h0000_0001;
        #1 chk("t2_stall", 32'(ct_ready), 0);
        tick();
        ks_valid = 1'b1; ks_in = 32'h0000_0010;
        #1 chk("t2_no_bypass", 32'(ct_ready), 0);
        tick();
        ks_valid = 1'b0;
        #1 chk("t2_ready", 32'(ct_ready), 1);
        tick();
        chk("t2_pv", 32'(pt_valid), 1);
        chk("t2_pt", pt_data, 32'h0000_0011);
        ct_valid = 1'b0;
        tick();
        chk("t2_count", 32'(pt_count), 3);

        // backpressure then overflow
        pt_ready = 1'b0;
        ks_valid = 1'b1; ks_in = 32'h0000_0022;
        tick();
        ks_valid = 1'b0; ct_valid = 1'b1; ct_data = 32'h0;
        #1 chk("t3_ready", 32'(ct_ready), 1);
        tick();
        chk("t3_pt", pt_data, 32'h0000_0022);
        ct_data = 32'h0000_DEAD;
        for (int i = 0; i < 4; i++) begin
            ks_valid = 1'b1; ks_in = 32'h100 + 32'(i);
            #1 chk("t3_bp_ready", 32'(ct_ready), 0);
            tick();
        end
        chk("t3_pt_stable", pt_data, 32'h0000_0022);
        chk("t3_no_err", 32'(err), 0);
        ks_in = 32'h0000_0104;
        tick();
        ks_valid = 1'b0;
        chk("t3_err", 32'(err), 1);
        pt_ready = 1'b1;
        #1 chk("t3_err_ready", 32'(ct_ready), 0);
        tick();
        chk("t3_drain_pv", 32'(pt_valid), 0);
        chk("t3_drain_count", 32'(pt_count), 4);
        chk("t3_err_sticky", 32'(err), 1);
        ct_valid = 1'b0;

        // restart from ERR, then stream with FIFO held full across wraps
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_err_clr", 32'(err), 0);
        chk("t4_count_clr", 32'(pt_count), 0);
        chk("t4_pv_clr", 32'(pt_valid), 0);
        #1 chk("t4_empty", 32'(ct_ready), 0);
        for (int i = 0; i < 4; i++) begin
            ks_valid = 1'b1; ks_in = ksw(i);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            ks_valid = 1'b1; ks_in = ksw(i + 4);
            ct_valid = 1'b1; ct_data = ctw(i);
            #1 chk("t4_full_ready", 32'(ct_ready), 1);
            tick();
            chk("t4_pt", pt_data, ctw(i) ^ ksw(i));
            chk("t4_count", 32'(pt_count), 32'(i[3:0]));
        end
        chk("t4_no_err", 32'(err), 0);
        ks_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ct_data = ctw(16 + j);
            #1 chk("t4_drain_ready", 32'(ct_ready), 1);
            tick();
            chk("t4_drain_pt", pt_data, ctw(16 + j) ^ ksw(16 + j));
            chk("t4_wrap_count", 32'(pt_count), 32'(j));
        end
        #1 chk("t4_drained", 32'(ct_ready), 0);
        ct_valid = 1'b0;
        tick();
        chk("t4_pv_end", 32'(pt_valid), 0);

        // reset mid-transfer, dominating start
        pt_ready = 1'b0;
        ks_valid = 1'b1; ks_in = 32'h0000_0055;
        tick();
        ks_in = 32'h0000_0066;
        tick();
        ks_valid = 1'b0; ct_valid = 1'b1; ct_data = 32'h0000_0F00;
        tick();
        chk("t5_pt", pt_data, 32'h0000_0F55);
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("t5_pv", 32'(pt_valid), 0);
        chk("t5_pt_data", pt_data, 0);
        chk("t5_err", 32'(err), 0);
        chk("t5_count", 32'(pt_count), 0);
        #1 chk("t5_idle_ready", 32'(ct_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1 chk("t5_fifo_cleared", 32'(ct_ready), 0);
        ct_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
